// File: rtl/approx_err_pkg.sv
// Shared constants, FSM state type and the absolute-difference helper for the
// approximate-partition error monitor.
package approx_err_pkg;

    localparam int W        = 5;
    localparam int LEN_W    = 16;
    localparam int HD_W     = 3;
    localparam int HD_SUM_W = 19;
    localparam int AE_SUM_W = 21;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_e;

    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

endpackage

// File: rtl/approx_err_popcnt.sv
// Combinational Hamming weight of a W-bit vector.
module approx_err_popcnt
    import approx_err_pkg::*;
(
    input  logic [W-1:0]    vec,
    output logic [HD_W-1:0] cnt
);

    // Sum of the individual bits.
    always_comb begin
        cnt = {HD_W{1'b0}};
        for (int i = 0; i < W; i++) begin
            cnt = cnt + {{(HD_W-1){1'b0}}, vec[i]};
        end
    end

endmodule

// File: rtl/approx_err_monitor.sv
// Frame-based error monitor comparing approximate vs exact partition outputs.
// Optional magnitude statistics (ae_sum/ae_max) are built with APPROX_ERR_MAG_EN.
module approx_err_monitor
    import approx_err_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    frame_len,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        approx,
    input  logic [W-1:0]        exact,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [LEN_W-1:0]    mis_cnt,
    output logic [HD_SUM_W-1:0] hd_sum,
    output logic [HD_W-1:0]     hd_max,
    output logic [AE_SUM_W-1:0] ae_sum,
    output logic [W-1:0]        ae_max
);

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      mis_cnt_q, mis_cnt_d;
    logic [HD_SUM_W-1:0]   hd_sum_q, hd_sum_d;
    logic [HD_W-1:0]       hd_max_q, hd_max_d;
    logic [HD_W-1:0]       hd_s;
    logic                  accept_s;
    logic                  clear_s;

    approx_err_popcnt u_popcnt (
        .vec (approx ^ exact),
        .cnt (hd_s)
    );

    assign accept_s = in_valid && (state_q == RUN) && !abort;

    // Next-state, frame control and Hamming accumulators.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        mis_cnt_d = mis_cnt_q;
        hd_sum_d  = hd_sum_q;
        hd_max_d  = hd_max_q;
        clear_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    clear_s   = 1'b1;
                    cnt_d     = {LEN_W{1'b0}};
                    len_d     = frame_len;
                    mis_cnt_d = {LEN_W{1'b0}};
                    hd_sum_d  = {HD_SUM_W{1'b0}};
                    hd_max_d  = {HD_W{1'b0}};
                    state_d   = (frame_len != {LEN_W{1'b0}}) ? RUN : REPORT;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept_s) begin
                    cnt_d     = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
                    mis_cnt_d = mis_cnt_q + {{(LEN_W-1){1'b0}}, (hd_s != {HD_W{1'b0}})};
                    hd_sum_d  = hd_sum_q + {{(HD_SUM_W-HD_W){1'b0}}, hd_s};
                    hd_max_d  = (hd_s > hd_max_q) ? hd_s : hd_max_q;
                    // cnt_q counts prior accepts, so this is sample number cnt_q+1
                    if (cnt_d == len_q) begin
                        state_d = REPORT;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            REPORT: begin
                if (abort || res_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = REPORT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= {LEN_W{1'b0}};
            len_q     <= {LEN_W{1'b0}};
            mis_cnt_q <= {LEN_W{1'b0}};
            hd_sum_q  <= {HD_SUM_W{1'b0}};
            hd_max_q  <= {HD_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            mis_cnt_q <= mis_cnt_d;
            hd_sum_q  <= hd_sum_d;
            hd_max_q  <= hd_max_d;
        end
    end

`ifdef APPROX_ERR_MAG_EN
    logic [AE_SUM_W-1:0] ae_sum_q, ae_sum_d;
    logic [W-1:0]        ae_max_q, ae_max_d;
    logic [W-1:0]        ae_s;

    assign ae_s = abs_diff(approx, exact);

    // Magnitude accumulators share the clear/hold rules of the Hamming ones.
    always_comb begin
        ae_sum_d = ae_sum_q;
        ae_max_d = ae_max_q;
        if (clear_s) begin
            ae_sum_d = {AE_SUM_W{1'b0}};
            ae_max_d = {W{1'b0}};
        end else if (accept_s) begin
            ae_sum_d = ae_sum_q + {{(AE_SUM_W-W){1'b0}}, ae_s};
            ae_max_d = (ae_s > ae_max_q) ? ae_s : ae_max_q;
        end else begin
            ae_sum_d = ae_sum_q;
            ae_max_d = ae_max_q;
        end
    end

    // Magnitude registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ae_sum_q <= {AE_SUM_W{1'b0}};
            ae_max_q <= {W{1'b0}};
        end else begin
            ae_sum_q <= ae_sum_d;
            ae_max_q <= ae_max_d;
        end
    end

    assign ae_sum = ae_sum_q;
    assign ae_max = ae_max_q;
`else
    assign ae_sum = {AE_SUM_W{1'b0}};
    assign ae_max = {W{1'b0}};
`endif

    assign in_ready  = (state_q == RUN);
    assign res_valid = (state_q == REPORT);
    assign mis_cnt   = mis_cnt_q;
    assign hd_sum    = hd_sum_q;
    assign hd_max    = hd_max_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed self-checking bench for approx_err_monitor (works with or without
// APPROX_ERR_MAG_EN; magnitude expectations follow the macro).
module tb_approx_err_monitor;
    import approx_err_pkg::*;

`ifdef APPROX_ERR_MAG_EN
    localparam bit MAG = 1'b1;
`else
    localparam bit MAG = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [LEN_W-1:0]    frame_len;
    logic                abort;
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        approx;
    logic [W-1:0]        exact;
    logic                res_valid;
    logic                res_ready;
    logic [LEN_W-1:0]    mis_cnt;
    logic [HD_SUM_W-1:0] hd_sum;
    logic [HD_W-1:0]     hd_max;
    logic [AE_SUM_W-1:0] ae_sum;
    logic [W-1:0]        ae_max;

    int n_cmp = 0;
    int n_err = 0;
    int accepts;
    bit ready_seen;
    bit valid_seen;

    approx_err_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .approx    (approx),
        .exact     (exact),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .mis_cnt   (mis_cnt),
        .hd_sum    (hd_sum),
        .hd_max    (hd_max),
        .ae_sum    (ae_sum),
        .ae_max    (ae_max)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input int m, input int hs, input int hm,
                           input int as, input int am);
        chk({tag, ".mis_cnt"}, 32'(mis_cnt), 32'(m));
        chk({tag, ".hd_sum"},  32'(hd_sum),  32'(hs));
        chk({tag, ".hd_max"},  32'(hd_max),  32'(hm));
        chk({tag, ".ae_sum"},  32'(ae_sum),  MAG ? 32'(as) : 32'd0);
        chk({tag, ".ae_max"},  32'(ae_max),  MAG ? 32'(am) : 32'd0);
    endtask

    task automatic do_start(input logic [LEN_W-1:0] len);
        start     = 1'b1;
        frame_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] e);
        in_valid = 1'b1;
        approx   = a;
        exact    = e;
        tick();
        in_valid = 1'b0;
    endtask

    logic [W-1:0] va [4];
    logic [W-1:0] ve [4];

    initial begin
        rst = 1'b1; start = 1'b0; frame_len = 16'd0; abort = 1'b0;
        in_valid = 1'b0; approx = 5'd0; exact = 5'd0; res_ready = 1'b0;
        #3;
        chk("rst.in_ready",  32'(in_ready),  32'd0);
        chk("rst.res_valid", 32'(res_valid), 32'd0);
        chk_res("rst", 0, 0, 0, 0, 0);
        #9 rst = 1'b0;
        tick();

        // Frame of 4: hd = 0,5,1,1; ae = 0,31,1,16
        va[0] = 5'h1F; ve[0] = 5'h1F;
        va[1] = 5'h00; ve[1] = 5'h1F;
        va[2] = 5'h05; ve[2] = 5'h04;
        va[3] = 5'h10; ve[3] = 5'h00;
        do_start(16'd4);
        chk("f4.in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) send(va[i], ve[i]);
        chk("f4.res_valid", 32'(res_valid), 32'd1);
        chk("f4.in_ready_off", 32'(in_ready), 32'd0);
        chk_res("f4", 3, 7, 5, 48, 31);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("f4.idle_valid", 32'(res_valid), 32'd0);
        chk("f4.idle_hold", 32'(mis_cnt), 32'd3);

        // Zero-length frame goes straight to REPORT
        do_start(16'd0);
        chk("f0.in_ready", 32'(in_ready), 32'd0);
        chk("f0.res_valid", 32'(res_valid), 32'd1);
        chk_res("f0", 0, 0, 0, 0, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("f0.idle", 32'(res_valid), 32'd0);

        // Frame of 3 with gapped in_valid and a stalled consumer
        do_start(16'd3);
        accepts = 0;
        approx = 5'h03; exact = 5'h00;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            if (in_valid && in_ready) accepts++;
            tick();
        end
        in_valid = 1'b0;
        chk("f3.accepts", 32'(accepts), 32'd3);
        chk("f3.res_valid", 32'(res_valid), 32'd1);
        start = 1'b1;
        frame_len = 16'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("f3.hold_valid", 32'(res_valid), 32'd1);
            chk_res("f3.hold", 3, 6, 2, 9, 3);
        end
        start = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("f3.idle_valid", 32'(res_valid), 32'd0);
        chk("f3.idle_ready", 32'(in_ready), 32'd0);

        // Abort after 2 of 8
        do_start(16'd8);
        send(5'h01, 5'h00);
        send(5'h01, 5'h00);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab.in_ready", 32'(in_ready), 32'd0);
        chk("ab.kept", 32'(mis_cnt), 32'd2);
        valid_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            tick();
            if (res_valid) valid_seen = 1'b1;
        end
        in_valid = 1'b0;
        chk("ab.no_valid", 32'(valid_seen), 32'd0);
        start = 1'b1; abort = 1'b1; frame_len = 16'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("ab.start_abort_idle", 32'(in_ready), 32'd0);
        do_start(16'd1);
        chk("ab.cleared", 32'(mis_cnt), 32'd0);
        send(5'h00, 5'h00);
        chk("ab.new_valid", 32'(res_valid), 32'd1);
        chk_res("ab.new", 0, 0, 0, 0, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Async reset between edges mid-RUN
        do_start(16'd8);
        for (int i = 0; i < 3; i++) send(5'h1F, 5'h00);
        chk("rr.pre", 32'(mis_cnt), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("rr.in_ready", 32'(in_ready), 32'd0);
        chk_res("rr", 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        ready_seen = 1'b0;
        valid_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            tick();
            if (in_ready) ready_seen = 1'b1;
            if (res_valid) valid_seen = 1'b1;
        end
        in_valid = 1'b0;
        chk("rr.ready_low", 32'(ready_seen), 32'd0);
        chk("rr.no_valid", 32'(valid_seen), 32'd0);

        // Maximum frame length, worst-case pairs
        do_start(16'hFFFF);
        in_valid = 1'b1; approx = 5'h00; exact = 5'h1F;
        for (int i = 0; i < 65534; i++) tick();
        chk("max.not_yet", 32'(res_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("max.res_valid", 32'(res_valid), 32'd1);
        chk_res("max", 65535, 327675, 5, 2031585, 31);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("max.idle", 32'(res_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
